// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : vga_pkg                                                           |
// | Brief  : Shared types, 640x480@60 timing constants and colour-bar table.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Per-pixel timing flags carried alongside the RAM read latency.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
    logic frame_start;
  } sync_t;

  localparam sync_t c_SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, valid: 1'b0, frame_start: 1'b0};

  function automatic int line_total(input int active, input int fp, input int sw, input int bp);
    return active + fp + sw + bp;
  endfunction

  localparam int c_VGA640_H_ACTIVE = 640;
  localparam int c_VGA640_H_FP     = 16;
  localparam int c_VGA640_H_SYNC   = 96;
  localparam int c_VGA640_H_BP     = 48;
  localparam int c_VGA640_V_ACTIVE = 480;
  localparam int c_VGA640_V_FP     = 10;
  localparam int c_VGA640_V_SYNC   = 2;
  localparam int c_VGA640_V_BP     = 33;
  localparam int c_VGA640_H_TOTAL  = line_total(c_VGA640_H_ACTIVE, c_VGA640_H_FP, c_VGA640_H_SYNC, c_VGA640_H_BP);
  localparam int c_VGA640_V_TOTAL  = line_total(c_VGA640_V_ACTIVE, c_VGA640_V_FP, c_VGA640_V_SYNC, c_VGA640_V_BP);

  // {R,G,B} enable bits for each of the eight vertical colour bars.
  localparam logic [7:0][2:0] c_BAR_RGB = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

endpackage
`default_nettype wire

// File: rtl/vga_fb_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : vga_fb_ram                                                        |
// | Brief  : Simple dual-port read-first RAM, RD_LAT-deep registered output.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module vga_fb_ram #(
  parameter int DEPTH  = 307200,
  parameter int AW     = 19,
  parameter int DW     = 24,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem     [DEPTH];
  logic [DW-1:0] r_rd_pipe [RD_LAT];
  logic          w_wr_ok;

  generate
    if ((1 << AW) == DEPTH) begin : g_full_range
      assign w_wr_ok = 1'b1;
    end else begin : g_range_check
      assign w_wr_ok = (32'(wr_addr) < DEPTH);
    end
  endgenerate

  // Read and write share one process so a same-address access returns old data.
  always_ff @(posedge clk) begin
    if (wr_en && w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_pipe[0] <= r_mem[rd_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      r_rd_pipe[i] <= r_rd_pipe[i-1];
    end
  end

  assign rd_data = r_rd_pipe[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/vga_fb_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : vga_fb_ctrl                                                       |
// | Brief  : VGA scan engine with integrated framebuffer and pixel replication.|
// |          Optional VGA_FB_TEST_PATTERN_EN adds tp_sel colour-bar override.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module vga_fb_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = c_VGA640_H_ACTIVE,
  parameter int H_FP        = c_VGA640_H_FP,
  parameter int H_SYNC      = c_VGA640_H_SYNC,
  parameter int H_BP        = c_VGA640_H_BP,
  parameter int V_ACTIVE    = c_VGA640_V_ACTIVE,
  parameter int V_FP        = c_VGA640_V_FP,
  parameter int V_SYNC      = c_VGA640_V_SYNC,
  parameter int V_BP        = c_VGA640_V_BP,
  parameter int SCALE_SHIFT = 0,
  parameter int PIX_W       = 24,
  parameter int RD_LAT      = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [$clog2((H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT))-1:0] wr_addr,
  input  logic [PIX_W-1:0]             wr_data,
`ifdef VGA_FB_TEST_PATTERN_EN
  input  logic                         tp_sel,
`endif
  output logic [$clog2(H_ACTIVE)-1:0]  h_addr,
  output logic [$clog2(V_ACTIVE)-1:0]  v_addr,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         valid,
  output logic [PIX_W/3-1:0]           vga_r,
  output logic [PIX_W/3-1:0]           vga_g,
  output logic [PIX_W/3-1:0]           vga_b,
  output logic                         frame_start
);

  localparam int c_FB_W     = H_ACTIVE >> SCALE_SHIFT;
  localparam int c_FB_H     = V_ACTIVE >> SCALE_SHIFT;
  localparam int c_FB_DEPTH = c_FB_W * c_FB_H;
  localparam int c_AW       = $clog2(c_FB_DEPTH);
  localparam int c_HAW      = $clog2(H_ACTIVE);
  localparam int c_VAW      = $clog2(V_ACTIVE);
  localparam int c_H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int c_V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int c_HCW      = $clog2(c_H_TOTAL);
  localparam int c_VCW      = $clog2(c_V_TOTAL);
  localparam int c_SW       = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam int c_CW       = PIX_W / 3;

  localparam logic [c_HCW-1:0] c_H_LAST     = c_HCW'(c_H_TOTAL - 1);
  localparam logic [c_HCW-1:0] c_H_ACT      = c_HCW'(H_ACTIVE);
  localparam logic [c_HCW-1:0] c_H_ACT_LAST = c_HCW'(H_ACTIVE - 1);
  localparam logic [c_HCW-1:0] c_HS_BEG     = c_HCW'(H_ACTIVE + H_FP);
  localparam logic [c_HCW-1:0] c_HS_END     = c_HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_VCW-1:0] c_V_LAST     = c_VCW'(c_V_TOTAL - 1);
  localparam logic [c_VCW-1:0] c_V_ACT      = c_VCW'(V_ACTIVE);
  localparam logic [c_VCW-1:0] c_V_ACT_LAST = c_VCW'(V_ACTIVE - 1);
  localparam logic [c_VCW-1:0] c_VS_BEG     = c_VCW'(V_ACTIVE + V_FP);
  localparam logic [c_VCW-1:0] c_VS_END     = c_VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [c_SW-1:0]  c_SUB_MAX    = c_SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [c_AW-1:0]  c_ROW_STEP   = c_AW'(c_FB_W);

  logic [c_HCW-1:0] r_h_cnt;
  logic [c_VCW-1:0] r_v_cnt;
  logic [c_SW-1:0]  r_x_sub, r_y_sub;
  logic [c_AW-1:0]  r_x_idx, r_row_base;
  logic             w_h_last, w_v_last, w_h_vis, w_v_vis;
  logic [c_AW-1:0]  w_rd_addr;
  logic [PIX_W-1:0] w_rd_data, w_pix;
  logic             w_wr_en;
  sync_t            w_sync;
  logic [c_HAW-1:0] w_h_addr;
  logic [c_VAW-1:0] w_v_addr;

  sync_t            r_sync   [RD_LAT];
  logic [c_HAW-1:0] r_h_pipe [RD_LAT];
  logic [c_VAW-1:0] r_v_pipe [RD_LAT];

  assign w_h_last = (r_h_cnt == c_H_LAST);
  assign w_v_last = (r_v_cnt == c_V_LAST);
  assign w_h_vis  = (r_h_cnt < c_H_ACT);
  assign w_v_vis  = (r_v_cnt < c_V_ACT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Framebuffer address tracks the scan incrementally; indices hold on the last
  // visible column/line so the address never leaves the buffer during blanking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x_sub    <= '0;
      r_x_idx    <= '0;
      r_y_sub    <= '0;
      r_row_base <= '0;
    end else begin
      if (w_h_last) begin
        r_x_sub <= '0;
        r_x_idx <= '0;
      end else if (w_h_vis && (r_h_cnt != c_H_ACT_LAST)) begin
        if (r_x_sub == c_SUB_MAX) begin
          r_x_sub <= '0;
          r_x_idx <= r_x_idx + 1'b1;
        end else begin
          r_x_sub <= r_x_sub + 1'b1;
        end
      end
      if (w_h_last) begin
        if (w_v_last) begin
          r_y_sub    <= '0;
          r_row_base <= '0;
        end else if (w_v_vis && (r_v_cnt != c_V_ACT_LAST)) begin
          if (r_y_sub == c_SUB_MAX) begin
            r_y_sub    <= '0;
            r_row_base <= r_row_base + c_ROW_STEP;
          end else begin
            r_y_sub <= r_y_sub + 1'b1;
          end
        end
      end
    end
  end

  assign w_rd_addr = r_row_base + r_x_idx;
  assign w_wr_en   = wr_en & resetn;

  always_comb begin
    w_sync             = c_SYNC_IDLE;
    w_sync.hsync       = !((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
    w_sync.vsync       = !((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));
    w_sync.valid       = w_h_vis && w_v_vis;
    w_sync.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_h_addr           = w_sync.valid ? c_HAW'(r_h_cnt) : '0;
    w_v_addr           = w_sync.valid ? c_VAW'(r_v_cnt) : '0;
  end

  // Timing side-band delayed to match the RAM read latency exactly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_sync[i]   <= c_SYNC_IDLE;
        r_h_pipe[i] <= '0;
        r_v_pipe[i] <= '0;
      end
    end else begin
      r_sync[0]   <= w_sync;
      r_h_pipe[0] <= w_h_addr;
      r_v_pipe[0] <= w_v_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_sync[i]   <= r_sync[i-1];
        r_h_pipe[i] <= r_h_pipe[i-1];
        r_v_pipe[i] <= r_v_pipe[i-1];
      end
    end
  end

  vga_fb_ram #(
    .DEPTH  (c_FB_DEPTH),
    .AW     (c_AW),
    .DW     (PIX_W),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  assign hsync       = r_sync[RD_LAT-1].hsync;
  assign vsync       = r_sync[RD_LAT-1].vsync;
  assign valid       = r_sync[RD_LAT-1].valid;
  assign frame_start = r_sync[RD_LAT-1].frame_start;
  assign h_addr      = r_h_pipe[RD_LAT-1];
  assign v_addr      = r_v_pipe[RD_LAT-1];

`ifdef VGA_FB_TEST_PATTERN_EN
  logic [2:0] w_bar;
  logic [2:0] w_bar_rgb;
  assign w_bar     = 3'((32'(h_addr) * 8) / H_ACTIVE);
  assign w_bar_rgb = c_BAR_RGB[w_bar];
  assign w_pix     = tp_sel ? {{c_CW{w_bar_rgb[2]}}, {c_CW{w_bar_rgb[1]}}, {c_CW{w_bar_rgb[0]}}}
                            : w_rd_data;
`else
  assign w_pix = w_rd_data;
`endif

  assign {vga_r, vga_g, vga_b} = valid ? w_pix : '0;

endmodule
`default_nettype wire

// File: doc/vga_fb_ctrl.md
Name: vga_fb_ctrl

Overview:
Parametrised VGA scan engine with an integrated dual-port framebuffer. It generates hsync/vsync/valid timing from configurable porch/sync widths and reads pixels from an internal RAM with registered, fixed-latency reads. It replicates pixels by 2^SCALE_SHIFT so low-resolution buffers fill the screen. A system-side write port lets the CPU or the keyboard/demo logic update the image at runtime; it replaces a combinational ROM image plus a separate timing controller.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
SCALE_SHIFT, 0, pixel/line replication factor 2^SCALE_SHIFT; FB_W=H_ACTIVE>>S, FB_H=V_ACTIVE>>S
PIX_W, 24, pixel width, {R,G,B} with equal thirds
RD_LAT, 1, RAM read latency in clocks, legal 1..3

Ports:
clk  in  1  pixel clock
resetn  in  1  synchronous, active-low reset
wr_en  in  1  framebuffer write strobe
wr_addr  in  $clog2(FB_W*FB_H)  linear address y*FB_W+x
wr_data  in  PIX_W  pixel to write
h_addr  out  $clog2(H_ACTIVE)  current visible column (aligned with rgb)
v_addr  out  $clog2(V_ACTIVE)  current visible line (aligned with rgb)
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
valid  out  1  high in visible region (drives blank_n)
vga_r, vga_g, vga_b  out  PIX_W/3 each  colour, zero when valid=0
frame_start  out  1  one-clock pulse with first visible pixel of each frame

Behaviour:
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments on h wrap, wraps after V_TOTAL-1.
- Visible: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE (visible region starts at count 0).
- hsync=0 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync=0 for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Read address from counters, no multiplier: x index advances every 2^S visible pixels, resets at line start; row base advances by FB_W every 2^S visible lines, resets at frame start.
- RAM read registered; stage pipeline of exactly RD_LAT clocks on hsync/vsync/valid/h_addr/v_addr/frame_start so every output aligns with rgb. Total counter-to-pin latency = RD_LAT.
- Write port: single-cycle, no backpressure; wr_addr >= FB_W*FB_H ignored. Same-address write and read in one clock: read returns old data (read-first).
- Reset (resetn=0 at clk edge): counters 0, all pipeline stages flushed; hsync=1, vsync=1, valid=0, rgb=0, frame_start=0, h_addr=v_addr=0. Framebuffer contents not cleared. Reset mid-frame restarts at h=0,v=0; first frame_start RD_LAT clocks after release.
- Writes ignored while resetn=0.

Optional Feature:
VGA_FB_TEST_PATTERN_EN: when defined, add input tp_sel (1 bit); tp_sel=1 replaces RAM data with 8 vertical colour bars (bar = h_addr*8/H_ACTIVE; colour bits {R,G,B}=bar[2:0], each channel all-ones or zero), same latency. Undefined: port absent, RAM data always used.

Decomposition:
- Package vga_pkg: pixel struct {r,g,b}, helper localparams for H_TOTAL/V_TOTAL, standard 640x480@60 timing constants, colour-bar table.
- Sub-module vga_fb_ram: simple dual-port RAM, one write port, one read port, RD_LAT-deep registered output, read-first; target for BRAM inference.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1, S=0, RD_LAT=1): after reset release, hsync low at counts 10-11, period 14 clocks; vsync low for line 5 only; frame period 14*7=98 clocks.
- Write addr 0=0xFF0000, addr 9=0x00FF00 (FB_W=8): first visible pixel rgb=FF,00,00; line 1 col 1 rgb=00,FF,00; porch rgb=0, valid=0.
- S=1, same timing: FB_W=4; write addr 0=0x123456 -> pixels (0,0),(1,0),(0,1),(1,1) all 0x123456.
- RD_LAT=3: frame_start, valid and rgb rise same cycle, 3 clocks after counter hits 0; hsync edge also shifted 3 clocks.
- Write to the address being read in the same cycle: old value shown that frame, new value next frame; wr_addr=FB_W*FB_H leaves all memory unchanged.
- Assert resetn=0 mid-line for 1 clock: next edge hsync=vsync=1, valid=0, rgb=0; frame restarts, frame_start after RD_LAT clocks; framebuffer data preserved.
